// File: rtl/mandel_dispatch_if.sv
// Pixel result stream from mandel_dispatch to the pixel packer.
// Uses valid/ready with start-of-frame and end-of-line flags.
interface mandel_dispatch_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_iter;
  logic        pix_sof;
  logic        pix_eol;

  modport master (output pix_valid, pix_iter, pix_sof, pix_eol, input pix_ready);
  modport slave  (input pix_valid, pix_iter, pix_sof, pix_eol, output pix_ready);
endinterface

// File: rtl/mandel_dispatch.sv
// mandel_dispatch: round-robin frame scheduler sharing NUM_CORES mandelbrot cores; results retire in raster order.
// Optional per-frame cycle/stall counters are enabled with the macro MANDEL_DISPATCH_PERF_EN.
module mandel_dispatch #(
  parameter int NUM_CORES = 4,
  parameter int X_SIZE    = 640,
  parameter int Y_SIZE    = 480
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [31:0]             x_start_i,
  input  logic [31:0]             y_start_i,
  input  logic [31:0]             step_i,
  input  logic [15:0]             max_iter_i,
  output logic [NUM_CORES-1:0]    core_start_o,
  output logic [32*NUM_CORES-1:0] core_x0_o,
  output logic [32*NUM_CORES-1:0] core_y0_o,
  output logic [15:0]             core_max_iter_o,
  input  logic [NUM_CORES-1:0]    core_done_i,
  input  logic [16*NUM_CORES-1:0] core_iter_i,
  mandel_dispatch_if.master       pix,
  output logic                    busy_o
`ifdef MANDEL_DISPATCH_PERF_EN
  ,
  output logic [31:0]             frame_cycles_o,
  output logic [31:0]             stall_cycles_o
`endif
);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [PW-1:0] LAST_CORE = PW'(NUM_CORES - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(Y_SIZE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] SL_FREE  = 2'd0;
  localparam logic [1:0] SL_BUSY  = 2'd1;
  localparam logic [1:0] SL_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_x_start;
  logic [31:0]   r_step;
  logic [15:0]   r_max_iter;
  logic [31:0]   r_x_acc;
  logic [31:0]   r_y_acc;
  logic [XW-1:0] r_dx;
  logic [YW-1:0] r_dy;
  logic [XW-1:0] r_rx;
  logic [YW-1:0] r_ry;
  logic [PW-1:0] r_d;
  logic [PW-1:0] r_r;
  logic [1:0]    r_slot_st  [NUM_CORES];
  logic [15:0]   r_slot_res [NUM_CORES];

  logic w_go, w_slot_free_d, w_disp, w_last_disp, w_valid, w_retire, w_last_ret;

  assign w_go          = (r_state == ST_IDLE) && enable_i;
  assign w_slot_free_d = (r_slot_st[r_d] == SL_FREE);
  assign w_disp        = (r_state == ST_RUN) && w_slot_free_d;
  assign w_last_disp   = w_disp && (r_dx == X_LAST) && (r_dy == Y_LAST);
  assign w_valid       = (r_slot_st[r_r] == SL_DONE);
  assign w_retire      = w_valid && pix.pix_ready;
  assign w_last_ret    = w_retire && (r_rx == X_LAST) && (r_ry == Y_LAST);

  // Outputs are gated by valid so that reset and idle present all zeros.
  assign pix.pix_valid   = w_valid;
  assign pix.pix_iter    = w_valid ? r_slot_res[r_r] : 16'd0;
  assign pix.pix_sof     = w_valid && (r_rx == '0) && (r_ry == '0);
  assign pix.pix_eol     = w_valid && (r_rx == X_LAST);
  assign busy_o          = (r_state != ST_IDLE);
  assign core_max_iter_o = r_max_iter;

  // Frame FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_go) r_state <= ST_RUN;
        ST_RUN:   if (w_last_disp) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_last_ret) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Config latch, dispatch cursor, coordinate accumulators and core start/x0/y0 drive
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x_start    <= 32'd0;
      r_step       <= 32'd0;
      r_max_iter   <= 16'd0;
      r_x_acc      <= 32'd0;
      r_y_acc      <= 32'd0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_d          <= '0;
      core_start_o <= '0;
      core_x0_o    <= '0;
      core_y0_o    <= '0;
    end else begin
      core_start_o <= '0;
      if (w_go) begin
        r_x_start  <= x_start_i;
        r_step     <= step_i;
        r_max_iter <= max_iter_i;
        r_x_acc    <= x_start_i;
        r_y_acc    <= y_start_i;
        r_dx       <= '0;
        r_dy       <= '0;
        r_d        <= '0;
      end else if (w_disp) begin
        core_start_o[r_d]                  <= 1'b1;
        core_x0_o[32*int'(r_d) +: 32]      <= r_x_acc;
        core_y0_o[32*int'(r_d) +: 32]      <= r_y_acc;
        r_d <= (r_d == LAST_CORE) ? '0 : r_d + 1'b1;
        if (r_dx == X_LAST) begin
          r_dx    <= '0;
          r_x_acc <= r_x_start;
          // y holds on the last line so the accumulator never runs past the frame
          if (r_dy != Y_LAST) begin
            r_dy    <= r_dy + 1'b1;
            r_y_acc <= r_y_acc + r_step;
          end
        end else begin
          r_dx    <= r_dx + 1'b1;
          r_x_acc <= r_x_acc + r_step;
        end
      end
    end
  end

  // Retire pointer and retire raster cursor
  always_ff @(posedge clk_i) begin
    if (rst_i || w_go) begin
      r_r  <= '0;
      r_rx <= '0;
      r_ry <= '0;
    end else if (w_retire) begin
      r_r <= (r_r == LAST_CORE) ? '0 : r_r + 1'b1;
      if (r_rx == X_LAST) begin
        r_rx <= '0;
        r_ry <= (r_ry == Y_LAST) ? '0 : r_ry + 1'b1;
      end else begin
        r_rx <= r_rx + 1'b1;
      end
    end
  end

  // Per-core slot state; done pulses outside BUSY fall through untouched
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        r_slot_st[k]  <= SL_FREE;
        r_slot_res[k] <= 16'd0;
      end
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        case (r_slot_st[k])
          SL_FREE: if (w_disp && (r_d == PW'(k))) r_slot_st[k] <= SL_BUSY;
          SL_BUSY: if (core_done_i[k]) begin
            r_slot_st[k]  <= SL_DONE;
            r_slot_res[k] <= core_iter_i[16*k +: 16];
          end
          SL_DONE: if (w_retire && (r_r == PW'(k))) r_slot_st[k] <= SL_FREE;
          default: r_slot_st[k] <= SL_FREE;
        endcase
      end
    end
  end

`ifdef MANDEL_DISPATCH_PERF_EN
  logic [31:0] r_frame_cnt;
  logic [31:0] r_stall_cnt;

  // Per-frame busy and stall counters, published when the last pixel retires
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_frame_cnt    <= 32'd0;
      r_stall_cnt    <= 32'd0;
      frame_cycles_o <= 32'd0;
      stall_cycles_o <= 32'd0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_frame_cnt <= 32'd0;
        r_stall_cnt <= 32'd0;
      end else begin
        if (r_frame_cnt != 32'hFFFF_FFFF) r_frame_cnt <= r_frame_cnt + 32'd1;
        if ((r_state == ST_RUN) && !w_slot_free_d && (r_stall_cnt != 32'hFFFF_FFFF))
          r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if ((r_state == ST_DRAIN) && w_last_ret) begin
        frame_cycles_o <= (r_frame_cnt == 32'hFFFF_FFFF) ? r_frame_cnt : r_frame_cnt + 32'd1;
        stall_cycles_o <= r_stall_cnt;
      end
    end
  end
`endif
endmodule
